hazard_unit_mc: RTL and testbench
=================================

# hazard_unit_mc

Parametrised multi-cycle hazard unit for the five-stage pipelined core. It replaces the single-cycle hazard logic and supports multi-bubble load-use stalls for a configurable load latency. It also adds a data-memory wait handshake that freezes F/D/E/M, a sticky memory-timeout flag, and load-aware M-stage forwarding. It sits beside the pipeline registers, takes register indices and control from D/E/M/W, and drives their stall/flush enables and the E-stage operand muxes.

## Interface
Parameters:
- REG_AW, 5: register index width; index 0 is hardwired zero.
- LOAD_STALL_CYCLES, 1: bubbles inserted on a load-use hazard, range 1..15.
- MEM_TIMEOUT, 255: wait cycles before MemTimeout is raised, at least 1.

Ports (name, direction, width, meaning):
- clk, in, 1: clock. One clock; all state is on the rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- Rs1D, Rs2D, in, REG_AW: decode source registers.
- Rs1E, Rs2E, RdE, in, REG_AW: execute sources and destination.
- ResultSrcE, in, 2: 2'b01 means a load is in E.
- PCSrcE, in, 2: 2'b01 or 2'b10 means a taken branch or jump.
- RdM, in, REG_AW; RegWriteM, in, 1; ResultSrcM, in, 2: memory-stage writeback info.
- MemReqM, in, 1; MemAckM, in, 1: data-memory request and completion.
- RdW, in, REG_AW; RegWriteW, in, 1: writeback info.
- StallF, StallD, StallE, StallM, out, 1: hold the corresponding pipeline register.
- FlushD, FlushE, FlushW, out, 1: bubble the corresponding pipeline register.
- ForwardAE, ForwardBE, out, 2: 00 selects the register file, 01 selects W, 10 selects M.
- MemTimeout, out, 1: sticky memory-timeout error flag.

## Operation
Forwarding (combinational):
- M is selected when Rs==RdM, RegWriteM, Rs!=0 and ResultSrcM!=2'b01.
- Otherwise W is selected when Rs==RdW, RegWriteW and Rs!=0.
- Otherwise 00.
- A load in M never forwards.

The FSM has three states: RUN, LDSTALL, MEMWAIT.
- memwait = MemReqM && !MemAckM.
- lwHaz = ResultSrcE==2'b01, RdE!=0, and (Rs1D==RdE or Rs2D==RdE).

Priority, highest first:
1. memwait, in any state: assert StallF/D/E/M and FlushW. Suppress FlushD/FlushE. Go to MEMWAIT, or stay there. The LDSTALL counter freezes.
2. lwHaz in RUN: assert StallF, StallD, FlushE. If LOAD_STALL_CYCLES>1, go to LDSTALL with cnt=LOAD_STALL_CYCLES-1.
3. In LDSTALL: assert StallF, StallD, FlushE and decrement cnt. Return to RUN when cnt reaches 1 and is consumed.
4. Taken branch (PCSrcE 01/10): assert FlushD and FlushE. This is exclusive with a load in E.

MEMWAIT exit:
- On !memwait, return to the saved state: RUN, or LDSTALL with its frozen cnt.
- The E instruction was held, so a pending branch flush or lwHaz re-evaluates on that cycle.

MemTimeout:
- wcnt increments each MEMWAIT cycle and saturates at MEM_TIMEOUT.
- When wcnt reaches MEM_TIMEOUT, MemTimeout sets and stays set until rst.
- The pipeline stays frozen while memwait holds.
- wcnt clears on leaving MEMWAIT.

Reset:
- State RUN, cnt=0, wcnt=0, MemTimeout=0.
- All stall/flush outputs are 0 unless combinationally asserted by inputs.
- Asserting rst mid-stall aborts the stall immediately.

## Timing
- Forwarding and all stall/flush outputs are combinational from the current inputs and state, valid in the same cycle.
- Load-use penalty is exactly LOAD_STALL_CYCLES bubbles plus any MEMWAIT cycles.
- A memory wait of k cycles: stalls are asserted for k cycles. MemAckM high in cycle k+1 releases the freeze in that same cycle.
- MemTimeout rises on the clock edge ending the MEM_TIMEOUT-th consecutive wait cycle.
- Counter widths: cnt is 4 bits; wcnt is $clog2(MEM_TIMEOUT+1) bits.

## Configuration
- HAZARD_PERF_EN defined: adds output ports StallCount[31:0] and FlushCount[31:0], both saturating and cleared by rst.
  - StallCount increments every cycle StallF is high.
  - FlushCount increments every cycle FlushD or FlushE is high.
- HAZARD_PERF_EN undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Forwarding:
  - Rs1E=5, RdM=5, RegWriteM=1, ResultSrcM=00, RdW=5, RegWriteW=1 -> ForwardAE=10.
  - Same with ResultSrcM=01 -> ForwardAE=01.
  - Rs1E=0 -> ForwardAE=00.
- Load-use, LOAD_STALL_CYCLES=3: load in E with RdE=7, Rs2D=7 -> StallF/StallD/FlushE high for exactly 3 cycles, then low.
- Load with RdE=0 and Rs1D=0 -> no stall.
- Taken branch, PCSrcE=01 -> FlushD=FlushE=1 for 1 cycle, stalls 0.
- Memory wait: MemReqM=1 with MemAckM low for 4 cycles, starting during LDSTALL with cnt=2 -> StallF/D/E/M and FlushW high for 4 cycles, then the remaining 2 bubbles complete. MemTimeout stays 0 with MEM_TIMEOUT=255.
- Timeout with MEM_TIMEOUT=3: hold MemAckM low for 5 cycles -> MemTimeout=1 after the 3rd cycle and still 1 after the ack. rst clears it asynchronously. Rerun with HAZARD_PERF_EN defined: StallCount=5.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Multi-cycle hazard unit: load-use bubbles, data-memory wait freeze with sticky timeout, E-stage forwarding.
// Optional perf counters (StallCount/FlushCount) are built when HAZARD_PERF_EN is defined.
module hazard_unit_mc #(
    parameter int REG_AW            = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [1:0]        ResultSrcE,
    input  logic [1:0]        PCSrcE,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic              MemReqM,
    input  logic              MemAckM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteW,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       StallCount,
    output logic [31:0]       FlushCount,
`endif
    output logic              MemTimeout
);

    localparam int             WCW     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [3:0]     LD_INIT = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [WCW-1:0] WC_MAX  = WCW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT} state_t;

    state_t         state_q, state_d, ret_q, ret_d, eff;
    logic [3:0]     cnt_q, cnt_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           tmo_q, tmo_d;
    logic           memwait, lw_haz, br_taken;

    // A load sitting in M has no data yet, so it never forwards.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (rs == '0)                                         return 2'b00;
        if (RegWriteM && rs == RdM && ResultSrcM != 2'b01)    return 2'b10;
        if (RegWriteW && rs == RdW)                           return 2'b01;
        return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E);
    assign ForwardBE = fwd_sel(Rs2E);

    assign memwait  = MemReqM && !MemAckM;
    assign lw_haz   = (ResultSrcE == 2'b01) && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
    assign br_taken = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);

    // On the release cycle the held E instruction is re-evaluated as if in the saved state.
    assign eff = (state_q == MEMWAIT) ? ret_q : state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        wcnt_d  = '0;
        tmo_d   = tmo_q;
        if (memwait) begin
            state_d = MEMWAIT;
            if (state_q != MEMWAIT) ret_d = state_q;
            wcnt_d = (wcnt_q == WC_MAX) ? wcnt_q : wcnt_q + 1'b1;
            if (wcnt_d == WC_MAX) tmo_d = 1'b1;
        end else begin
            state_d = eff;
            case (eff)
                LDSTALL: begin
                    if (cnt_q <= 4'd1) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    if (lw_haz && LOAD_STALL_CYCLES > 1) begin
                        state_d = LDSTALL;
                        cnt_d   = LD_INIT;
                    end
                end
            endcase
        end
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (memwait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (eff == LDSTALL || lw_haz) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (br_taken) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign MemTimeout = tmo_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] sc_q, fc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_q <= '0;
            fc_q <= '0;
        end else begin
            if (StallF && sc_q != '1)             sc_q <= sc_q + 32'd1;
            if ((FlushD || FlushE) && fc_q != '1) fc_q <= fc_q + 32'd1;
        end
    end

    assign StallCount = sc_q;
    assign FlushCount = fc_q;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: two instances (3-bubble/255-timeout and 1-bubble/3-timeout) on shared inputs,
// directed scenarios plus random stimulus against a bubble-count reference model.
module tb_hazard_unit_mc;

    localparam int A_LSC = 3, A_MT = 255;
    localparam int B_LSC = 1, B_MT = 3;

    logic       clk, rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE, PCSrcE, ResultSrcM;
    logic       RegWriteM, RegWriteW, MemReqM, MemAckM;

    logic [1:0] StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [1:0] ForwardAE [2];
    logic [1:0] ForwardBE [2];
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCount [2];
    logic [31:0] FlushCount [2];
`endif

    int checks = 0;
    int failures = 0;

    hazard_unit_mc #(.REG_AW(5), .LOAD_STALL_CYCLES(A_LSC), .MEM_TIMEOUT(A_MT)) u_a (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
        .ResultSrcM(ResultSrcM), .MemReqM(MemReqM), .MemAckM(MemAckM), .RdW(RdW), .RegWriteW(RegWriteW),
        .StallF(StallF[0]), .StallD(StallD[0]), .StallE(StallE[0]), .StallM(StallM[0]),
        .FlushD(FlushD[0]), .FlushE(FlushE[0]), .FlushW(FlushW[0]),
        .ForwardAE(ForwardAE[0]), .ForwardBE(ForwardBE[0]),
`ifdef HAZARD_PERF_EN
        .StallCount(StallCount[0]), .FlushCount(FlushCount[0]),
`endif
        .MemTimeout(MemTimeout[0]));

    hazard_unit_mc #(.REG_AW(5), .LOAD_STALL_CYCLES(B_LSC), .MEM_TIMEOUT(B_MT)) u_b (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
        .ResultSrcM(ResultSrcM), .MemReqM(MemReqM), .MemAckM(MemAckM), .RdW(RdW), .RegWriteW(RegWriteW),
        .StallF(StallF[1]), .StallD(StallD[1]), .StallE(StallE[1]), .StallM(StallM[1]),
        .FlushD(FlushD[1]), .FlushE(FlushE[1]), .FlushW(FlushW[1]),
        .ForwardAE(ForwardAE[1]), .ForwardBE(ForwardBE[1]),
`ifdef HAZARD_PERF_EN
        .StallCount(StallCount[1]), .FlushCount(FlushCount[1]),
`endif
        .MemTimeout(MemTimeout[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remaining bubbles, consecutive wait cycles, sticky timeout, perf tallies.
    int m_bub [2];
    int m_wc  [2];
    bit m_to  [2];
    int m_sc  [2];
    int m_fc  [2];

    function automatic int lsc(input int k); return (k == 0) ? A_LSC : B_LSC; endfunction
    function automatic int mt(input int k);  return (k == 0) ? A_MT  : B_MT;  endfunction

    function automatic bit mw_now();
        return MemReqM && !MemAckM;
    endfunction

    function automatic bit lw_now();
        return ResultSrcE == 2'b01 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
    endfunction

    function automatic bit br_now();
        return PCSrcE == 2'b01 || PCSrcE == 2'b10;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (RegWriteM && rs == RdM && ResultSrcM != 2'b01) return 2'b10;
        if (RegWriteW && rs == RdW) return 2'b01;
        return 2'b00;
    endfunction

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE,MemTimeout}
    function automatic logic [11:0] exp_out(input int k);
        logic [6:0] sf;
        sf = 7'b0;
        if (mw_now())                     sf = 7'b1111001;
        else if (m_bub[k] > 0 || lw_now()) sf = 7'b1100010;
        else if (br_now())                sf = 7'b0000110;
        return {sf, ref_fwd(Rs1E), ref_fwd(Rs2E), m_to[k]};
    endfunction

    function automatic logic [11:0] obs(input int k);
        return {StallF[k], StallD[k], StallE[k], StallM[k], FlushD[k], FlushE[k], FlushW[k],
                ForwardAE[k], ForwardBE[k], MemTimeout[k]};
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_bub[k] <= 0; m_wc[k] <= 0; m_to[k] <= 1'b0; m_sc[k] <= 0; m_fc[k] <= 0;
            end else begin
                if (mw_now()) begin
                    m_wc[k] <= (m_wc[k] + 1 > mt(k)) ? mt(k) : m_wc[k] + 1;
                    if (m_wc[k] + 1 >= mt(k)) m_to[k] <= 1'b1;
                    m_sc[k] <= m_sc[k] + 1;
                end else begin
                    m_wc[k] <= 0;
                    if (m_bub[k] > 0) m_bub[k] <= m_bub[k] - 1;
                    else if (lw_now()) m_bub[k] <= lsc(k) - 1;
                    if (m_bub[k] > 0 || lw_now()) begin
                        m_sc[k] <= m_sc[k] + 1;
                        m_fc[k] <= m_fc[k] + 1;
                    end else if (br_now()) begin
                        m_fc[k] <= m_fc[k] + 1;
                    end
                end
            end
        end
    end

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; PCSrcE = 0; ResultSrcM = 0;
        RegWriteM = 0; RegWriteW = 0; MemReqM = 0; MemAckM = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        #3;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== 12'b0) begin
                failures++; $display("FAIL reset_outputs inst=%0d got=%b want=%b", k, obs(k), 12'b0);
            end
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (obs(0) !== 12'b0 || obs(1) !== 12'b0) begin
            failures++; $display("FAIL reset_release got=%b/%b want=0", obs(0), obs(1));
        end
    endtask

    task automatic test_forward();
        logic [1:0] want;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idle();
            Rs1E = 5; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
            case (i)
                0: begin ResultSrcM = 2'b00; want = 2'b10; end
                1: begin ResultSrcM = 2'b01; want = 2'b01; end
                2: begin Rs1E = 0;           want = 2'b00; end
                3: begin RegWriteM = 0;      want = 2'b01; end
                default: begin RegWriteM = 0; RegWriteW = 0; want = 2'b00; end
            endcase
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (ForwardAE[k] !== want) begin
                    failures++; $display("FAIL forward_a case=%0d inst=%0d got=%b want=%b", i, k, ForwardAE[k], want);
                end
            end
            checks++;
            if (ForwardBE[0] !== (i == 2 ? 2'b10 : want)) begin
                failures++; $display("FAIL forward_b case=%0d got=%b", i, ForwardBE[0]);
            end
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idle();
            if (i == 0) begin ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; Rs1D = 3; end
            #1;
            checks++;
            if (obs(0)[11:5] !== ((i < A_LSC) ? 7'b1100010 : 7'b0)) begin
                failures++; $display("FAIL load_use_a cycle=%0d got=%b", i, obs(0)[11:5]);
            end
            checks++;
            if (obs(1)[11:5] !== ((i < B_LSC) ? 7'b1100010 : 7'b0)) begin
                failures++; $display("FAIL load_use_b cycle=%0d got=%b", i, obs(1)[11:5]);
            end
        end
    endtask

    task automatic test_no_stall();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle();
            ResultSrcE = 2'b01;
            if (i == 0) begin RdE = 0; Rs1D = 0; end
            else begin RdE = 7; Rs1D = 6; Rs2D = 5; end
            #1;
            checks++;
            if (obs(0)[11:5] !== 7'b0 || obs(1)[11:5] !== 7'b0) begin
                failures++; $display("FAIL no_stall case=%0d got=%b/%b want=0", i, obs(0)[11:5], obs(1)[11:5]);
            end
        end
    endtask

    task automatic test_branch();
        logic [1:0] pcs [4];
        pcs[0] = 2'b01; pcs[1] = 2'b00; pcs[2] = 2'b10; pcs[3] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle(); PCSrcE = pcs[i]; #1;
            checks++;
            if (obs(0)[11:5] !== ((i == 0 || i == 2) ? 7'b0000110 : 7'b0)) begin
                failures++; $display("FAIL branch pcsrc=%b got=%b", pcs[i], obs(0)[11:5]);
            end
        end
    endtask

    task automatic test_memwait();
        logic [6:0] want;
        // wait arriving in the middle of a 3-bubble load stall
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); idle();
            if (i == 0) begin ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; end
            if (i >= 1 && i <= 5) MemReqM = 1;
            if (i == 5) MemAckM = 1;
            #1;
            want = (i >= 1 && i <= 4) ? 7'b1111001 : (i == 7) ? 7'b0 : 7'b1100010;
            checks++;
            if (obs(0)[11:5] !== want || MemTimeout[0] !== 1'b0) begin
                failures++; $display("FAIL memwait_ldstall cycle=%0d got=%b to=%b want=%b to=0", i, obs(0)[11:5], MemTimeout[0], want);
            end
        end
        // branch held through a wait flushes on the release cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle();
            if (i < 3) begin PCSrcE = 2'b01; MemReqM = 1; end
            if (i == 2) MemAckM = 1;
            #1;
            want = (i < 2) ? 7'b1111001 : (i == 2) ? 7'b0000110 : 7'b0;
            checks++;
            if (obs(0)[11:5] !== want) begin
                failures++; $display("FAIL memwait_branch cycle=%0d got=%b want=%b", i, obs(0)[11:5], want);
            end
        end
        // load-use held through a wait starts its bubbles on release
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); idle();
            if (i < 3) begin ResultSrcE = 2'b01; RdE = 9; Rs1D = 9; MemReqM = 1; end
            if (i == 2) MemAckM = 1;
            #1;
            want = (i < 2) ? 7'b1111001 : (i < 5) ? 7'b1100010 : 7'b0;
            checks++;
            if (obs(0)[11:5] !== want) begin
                failures++; $display("FAIL memwait_lw cycle=%0d got=%b want=%b", i, obs(0)[11:5], want);
            end
        end
    endtask

    task automatic test_timeout();
        @(negedge clk); rst = 1'b1; idle(); #1;
        checks++;
        if (MemTimeout !== 2'b00) begin
            failures++; $display("FAIL timeout_reset got=%b want=00", MemTimeout);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); idle();
            if (i < 6) MemReqM = 1;
            if (i == 5) MemAckM = 1;
            #1;
            checks++;
            if (MemTimeout[1] !== (i >= B_MT) || MemTimeout[0] !== 1'b0) begin
                failures++; $display("FAIL timeout_flag cycle=%0d got=%b want=%b0", i, MemTimeout, (i >= B_MT));
            end
            checks++;
            if (StallM[1] !== (i < 5) || StallF[1] !== (i < 5)) begin
                failures++; $display("FAIL timeout_freeze cycle=%0d got stallF=%b stallM=%b", i, StallF[1], StallM[1]);
            end
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (StallCount[1] !== 32'd5 || StallCount[0] !== 32'd5 || FlushCount[1] !== 32'd0) begin
            failures++; $display("FAIL perf_count got stall=%0d/%0d flush=%0d want 5/5/0", StallCount[0], StallCount[1], FlushCount[1]);
        end
`endif
        #1 rst = 1'b1; #1;
        checks++;
        if (MemTimeout[1] !== 1'b0) begin
            failures++; $display("FAIL timeout_async_clear got=%b want=0", MemTimeout[1]);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (StallCount[1] !== 32'd0) begin
            failures++; $display("FAIL perf_clear got=%0d want=0", StallCount[1]);
        end
`endif
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk); idle(); ResultSrcE = 2'b01; RdE = 4; Rs1D = 4;
        @(negedge clk); idle(); #1;
        checks++;
        if (StallF[0] !== 1'b1) begin
            failures++; $display("FAIL mid_stall_pre got=%b want=1", StallF[0]);
        end
        #1 rst = 1'b1; #1;
        checks++;
        if (StallF[0] !== 1'b0 || FlushE[0] !== 1'b0) begin
            failures++; $display("FAIL mid_stall_abort got=%b%b want=00", StallF[0], FlushE[0]);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (StallF[0] !== 1'b0) begin
            failures++; $display("FAIL mid_stall_after got=%b want=0", StallF[0]);
        end
    endtask

    task automatic test_random();
        @(negedge clk); rst = 1'b1; idle();
        @(negedge clk); rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 299) == 0);
            Rs1D       = 5'($urandom_range(0, 3));
            Rs2D       = 5'($urandom_range(0, 3));
            Rs1E       = 5'($urandom_range(0, 3));
            Rs2E       = 5'($urandom_range(0, 3));
            RdE        = 5'($urandom_range(0, 3));
            RdM        = 5'($urandom_range(0, 3));
            RdW        = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            ResultSrcM = 2'($urandom_range(0, 3));
            PCSrcE     = (ResultSrcE == 2'b01) ? 2'b00 : 2'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            MemReqM    = ($urandom_range(0, 2) == 0);
            MemAckM    = ($urandom_range(0, 2) == 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== exp_out(k)) begin
                    failures++; $display("FAIL random n=%0d inst=%0d got=%b want=%b", n, k, obs(k), exp_out(k));
                end
`ifdef HAZARD_PERF_EN
                checks++;
                if (StallCount[k] !== 32'(m_sc[k]) || FlushCount[k] !== 32'(m_fc[k])) begin
                    failures++; $display("FAIL random_perf n=%0d inst=%0d got=%0d/%0d want=%0d/%0d", n, k, StallCount[k], FlushCount[k], m_sc[k], m_fc[k]);
                end
`endif
            end
        end
        @(negedge clk); rst = 1'b0; idle();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_no_stall();
        test_branch();
        test_memwait();
        test_timeout();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
